alu_seq: RTL and testbench

- Parametrised successor to the single-cycle datapath ALU.
- Executes the RV32I ALU op set plus iterative unsigned multiply and divide.
- Uses a valid/ready handshake on both input and output, so the control path can stall on multi-cycle ops.
- Sits between the register file/immediate mux and writeback. Operand-2 selection is done upstream; this block sees two operands only.

---
 rtl/alu_seq.sv | 169 ++++++++++++++++
 tb/tb_alu_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: RV32I-style single-cycle ops plus iterative unsigned multiply/divide,
// with valid/ready handshakes on request and result.
module alu_seq #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [D_WIDTH-1:0] aluop1,
  input  logic [D_WIDTH-1:0] aluop2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] aluout,
  output logic               eq,
  output logic               busy
);

  localparam int SH_W = $clog2(D_WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               state;
  logic [3:0]           op_q;
  logic [2*D_WIDTH-1:0] acc;
  logic [D_WIDTH-1:0]   opnd;
  logic [SH_W-1:0]      cnt;

  logic [D_WIDTH:0]     mul_sum;
  logic [2*D_WIDTH-1:0] mul_next;
  logic [D_WIDTH:0]     div_sh;
  logic [D_WIDTH:0]     div_diff;
  logic                 div_ge;
  logic [2*D_WIDTH-1:0] div_next;

  function automatic logic [D_WIDTH-1:0] alu_compute(
    input logic [3:0]         f_op,
    input logic [D_WIDTH-1:0] a,
    input logic [D_WIDTH-1:0] b
  );
    logic signed [D_WIDTH-1:0] sa;
    logic signed [D_WIDTH-1:0] sb;
    logic signed [D_WIDTH-1:0] sra_r;
    logic [SH_W-1:0]           sh;
    logic [D_WIDTH-1:0]        res;
    sa    = a;
    sb    = b;
    sh    = b[SH_W-1:0];
    sra_r = sa >>> sh;
    res   = '0;
    case (f_op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SLT:  res = {{(D_WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLTU: res = {{(D_WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  res = a << sh;
      OP_SRL:  res = a >> sh;
      OP_SRA:  res = sra_r;
      default: res = '0;
    endcase
    return res;
  endfunction

  // Iteration step: acc holds {partial product, multiplier} for MUL and {remainder, dividend} for DIV
  always_comb begin
    mul_sum  = {1'b0, acc[2*D_WIDTH-1:D_WIDTH]} + (acc[0] ? {1'b0, opnd} : {(D_WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[D_WIDTH-1:1]};
    div_sh   = {acc[2*D_WIDTH-1:D_WIDTH], acc[D_WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opnd});
    div_diff = div_ge ? (div_sh - {1'b0, opnd}) : div_sh;
    div_next = {div_diff[D_WIDTH-1:0], acc[D_WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      aluout    <= '0;
      eq        <= 1'b0;
      op_q      <= '0;
      acc       <= '0;
      opnd      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_q     <= op;
            eq       <= (aluop1 == aluop2);
            cnt      <= '0;
            in_ready <= 1'b0;
            if (op == OP_MUL || op == OP_MULHU) begin
              acc   <= {{D_WIDTH{1'b0}}, aluop2};
              opnd  <= aluop1;
              busy  <= 1'b1;
              state <= MUL;
            end else if ((op == OP_DIVU || op == OP_REMU) && aluop2 != '0) begin
              acc   <= {{D_WIDTH{1'b0}}, aluop1};
              opnd  <= aluop2;
              busy  <= 1'b1;
              state <= DIV;
            end else if (op == OP_DIVU || op == OP_REMU) begin
              // Divide by zero resolves immediately, RISC-V style
              aluout    <= (op == OP_DIVU) ? {D_WIDTH{1'b1}} : aluop1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              aluout    <= alu_compute(op, aluop1, aluop2);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            aluout    <= (op_q == OP_MULHU) ? mul_next[2*D_WIDTH-1:D_WIDTH] : mul_next[D_WIDTH-1:0];
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            aluout    <= (op_q == OP_REMU) ? div_next[2*D_WIDTH-1:D_WIDTH] : div_next[D_WIDTH-1:0];
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at D_WIDTH=32.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] aluop1;
  logic [31:0] aluop2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] aluout;
  logic        eq;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  alu_seq #(.D_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .aluop1(aluop1), .aluop2(aluop2), .out_valid(out_valid), .out_ready(out_ready),
    .aluout(aluout), .eq(eq), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 100) check({tag, "_rdy_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Issue one request with out_ready=1 and check result, flags, latency and busy profile.
  task automatic run(input string tag, input logic [3:0] f_op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input logic exp_eq,
                     input int exp_lat);
    int lat, nbusy, nrdy;
    wait_ready(tag);
    out_ready = 1'b1;
    op = f_op; aluop1 = a; aluop2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; nbusy = 0; nrdy = 0;
    while (!out_valid && lat < 100) begin
      if (busy) nbusy++;
      if (in_ready) nrdy++;
      @(posedge clk); #1; lat++;
    end
    if (in_ready) nrdy++;
    check({tag, "_lat"},  32'(lat), 32'(exp_lat));
    check({tag, "_out"},  aluout, exp);
    check({tag, "_eq"},   32'(eq), 32'(exp_eq));
    check({tag, "_busy"}, 32'(nbusy), 32'(exp_lat - 1));
    check({tag, "_nordy"}, 32'(nrdy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int bad;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; aluop1 = '0; aluop2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_aluout",    aluout,         32'd0);
    check("rst_eq",        32'(eq),        32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    run("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
    run("sub_eq",   4'b0001, 32'd5,         32'd5,         32'h0000_0000, 1'b1, 1);
    run("and",      4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1);
    run("or",       4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1);
    run("xor",      4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1);
    run("sra",      4'b1001, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1);
    run("srl",      4'b1000, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 1);
    run("slt_neg",  4'b0101, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0, 1);
    run("sltu",     4'b0110, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1);
    run("sll31",    4'b0111, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1);
    run("sll0",     4'b0111, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1'b0, 1);
    run("op_e",     4'b1110, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b0, 1);
    run("mul",      4'b1010, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 33);
    run("mulhu",    4'b1011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b1, 33);
    run("mul_ff",   4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 33);
    run("mulhu_ff", 4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 33);
    run("divu",     4'b1100, 32'd100,       32'd7,         32'd14,        1'b0, 33);
    run("remu",     4'b1101, 32'd100,       32'd7,         32'd2,         1'b0, 33);
    run("divu_big", 4'b1100, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 1'b0, 33);
    run("divu_z",   4'b1100, 32'h0000_0055, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1);
    run("remu_z",   4'b1101, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b0, 1);

    // Backpressure: result held while new requests are presented
    wait_ready("bp");
    out_ready = 1'b0;
    op = 4'b0000; aluop1 = 32'd10; aluop2 = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 4'b0001; aluop1 = 32'd7; aluop2 = 32'd7;
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_out",   aluout,         32'd30);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (aluout !== 32'd30 || eq !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    check("bp_hold", 32'(bad), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_no_accept_valid", 32'(out_valid), 32'd0);
    check("bp_idle_ready",      32'(in_ready),  32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_out",   aluout,         32'd0);
    check("bp_next_eq",    32'(eq),        32'd1);
    @(posedge clk); #1;

    // Async reset during a divide
    wait_ready("rdiv");
    op = 4'b1100; aluop1 = 32'd100; aluop2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rdiv_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rdiv_out_valid", 32'(out_valid), 32'd0);
    check("rdiv_busy",      32'(busy),      32'd0);
    check("rdiv_aluout",    aluout,         32'd0);
    check("rdiv_in_ready",  32'(in_ready),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rdiv_rel_ready", 32'(in_ready), 32'd1);
    run("post_rst_add", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
